rx_frame_buffer: RTL and testbench

RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

---
 rtl/uart_pkg.sv | 15 +
 rtl/rx_fifo.sv | 77 +++++++
 rtl/rx_frame_buffer.sv | 143 ++++++++++++++
 tb/tb_rx_frame_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared defaults and control-state encoding for the UART receive buffer.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ERR_CNT_W_DEF  = 8;

  // Framing control states, tracking how many data bits are collected.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_FULLBYTE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO: head entry drives rd_data directly
// from storage; a push into a full FIFO is dropped unless a pop frees a slot
// in the same cycle.
module rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] push_data_i,
  input  logic                 pop_req_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic [CW-1:0]        count_o,
  output logic                 drop_o
);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 pop_s, full_s, push_ok_s;

  // Pointer, occupancy and storage next-state; pointers wrap naturally at AW bits.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop_s     = (count_q != {CW{1'b0}}) && pop_req_i;
    full_s    = (count_q == CW'(FIFO_DEPTH));
    push_ok_s = push_i && (!full_s || pop_s);
    drop_o    = push_i && full_s && !pop_s;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_BITS{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_valid_o = (count_q != {CW{1'b0}});
  assign count_o    = count_q;

endmodule

// File: rtl/rx_frame_buffer.sv
// UART receive framing: assembles LSB-first data bits, accepts complete
// frames into a FWFT FIFO, and counts rejected frames and overruns.
module rx_frame_buffer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ERR_CNT_W  = ERR_CNT_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_in,
  input  logic                            shift_en,
  input  logic                            done,
  input  logic                            err,
  input  logic                            rx_ready,
  input  logic                            err_clr,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overrun,
  output logic                            overrun_sticky,
  output logic [ERR_CNT_W-1:0]            err_cnt
);

  localparam int BW = $clog2(DATA_BITS + 1);

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 sticky_q, sticky_d;
  logic                 accept_s, reject_s, push_s, drop_s, frame_end_s;

  // Frame decode: a frame is rejected on err or on done with a short bit count.
  always_comb begin
    frame_end_s = done || err;
    accept_s    = done && !err && (bcnt_q == BW'(DATA_BITS));
    reject_s    = err || (done && (bcnt_q != BW'(DATA_BITS)));
    push_s      = accept_s && !rst;
  end

  // Shift register, bit counter and control state next-state.
  always_comb begin
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    state_d = state_q;
    if (shift_en) begin
      sr_d = {rx_in, sr_q[DATA_BITS-1:1]};
    end else begin
      sr_d = sr_q;
    end
    if (frame_end_s) begin
      bcnt_d = {BW{1'b0}};
    end else if (shift_en && (bcnt_q != BW'(DATA_BITS))) begin
      bcnt_d = bcnt_q + BW'(1);
    end else begin
      bcnt_d = bcnt_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (frame_end_s) begin
          state_d = ST_IDLE;
        end else if (shift_en) begin
          state_d = (DATA_BITS == 1) ? ST_FULLBYTE : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (frame_end_s) begin
          state_d = ST_IDLE;
        end else if (shift_en && (bcnt_q == BW'(DATA_BITS - 1))) begin
          state_d = ST_FULLBYTE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_FULLBYTE: begin
        if (frame_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FULLBYTE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Error counter and overrun flag; a clear coinciding with a new event keeps that event.
  always_comb begin
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    if (err_clr) begin
      err_cnt_d = reject_s ? ERR_CNT_W'(1) : {ERR_CNT_W{1'b0}};
      sticky_d  = drop_s;
    end else begin
      if (reject_s && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      sticky_d = sticky_q || drop_s;
    end
  end

  // Framing and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= {DATA_BITS{1'b0}};
      bcnt_q    <= {BW{1'b0}};
      err_cnt_q <= {ERR_CNT_W{1'b0}};
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bcnt_q    <= bcnt_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (sr_q),
    .pop_req_i   (rx_ready),
    .rd_data_o   (rx_data),
    .rd_valid_o  (rx_valid),
    .count_o     (fifo_count),
    .drop_o      (drop_s)
  );

  assign overrun        = drop_s;
  assign overrun_sticky = sticky_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Self-checking bench for rx_frame_buffer: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_rx_frame_buffer;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int EW    = 8;
  localparam int EMAX  = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst, rx_in, shift_en, done, err, rx_ready, err_clr;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic [2:0]    fifo_count;
  logic          overrun, overrun_sticky;
  logic [EW-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_q[$];
  int          m_bcnt;
  int unsigned m_sr;
  int          m_errs;
  bit          m_sticky;

  always #5 clk = ~clk;

  rx_frame_buffer #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .ERR_CNT_W(EW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_in          (rx_in),
    .shift_en       (shift_en),
    .done           (done),
    .err            (err),
    .rx_ready       (rx_ready),
    .err_clr        (err_clr),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .fifo_count     (fifo_count),
    .overrun        (overrun),
    .overrun_sticky (overrun_sticky),
    .err_cnt        (err_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check outputs, advance model.
  task automatic step(input bit r, input bit sh, input bit b, input bit d,
                      input bit e, input bit rdy, input bit clr);
    bit pop, accept, reject, exp_ovr;
    @(negedge clk);
    rst = r; shift_en = sh; rx_in = b; done = d; err = e; rx_ready = rdy; err_clr = clr;
    #1;
    pop     = (m_q.size() > 0) && rdy;
    accept  = d && !e && (m_bcnt == DB);
    reject  = e || (d && (m_bcnt != DB));
    exp_ovr = !r && accept && (m_q.size() == DEPTH) && !pop;
    check_val("rx_valid", rx_valid, (m_q.size() > 0) ? 1 : 0);
    check_val("fifo_count", fifo_count, m_q.size());
    if (m_q.size() > 0) check_val("rx_data", rx_data, m_q[0]);
    check_val("overrun", overrun, exp_ovr);
    check_val("overrun_sticky", overrun_sticky, m_sticky);
    check_val("err_cnt", err_cnt, m_errs);
    if (r) begin
      m_q.delete();
      m_bcnt = 0; m_sr = 0; m_errs = 0; m_sticky = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (accept && !exp_ovr) m_q.push_back(m_sr);
      if (sh) m_sr = (m_sr >> 1) | (int'(b) << (DB - 1));
      if (d || e) m_bcnt = 0;
      else if (sh && m_bcnt < DB) m_bcnt++;
      if (clr) m_errs = reject ? 1 : 0;
      else if (reject && m_errs < EMAX) m_errs++;
      m_sticky = clr ? exp_ovr : (m_sticky | exp_ovr);
    end
  endtask

  task automatic send_frame(input logic [7:0] val, input bit rdy_at_done);
    for (int i = 0; i < DB; i++) step(0, 1, val[i], 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, rdy_at_done, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b0; shift_en = 1'b0; done = 1'b0; err = 1'b0;
    rx_ready = 1'b0; err_clr = 1'b0;
    m_bcnt = 0; m_sr = 0; m_errs = 0; m_sticky = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Single 0xA5 frame arrives one cycle after done
    send_frame(8'hA5, 0);
    idle(1);
    check_val("a5_valid", rx_valid, 1);
    check_val("a5_data", rx_data, 8'hA5);
    check_val("a5_count", fifo_count, 1);
    step(0, 0, 0, 0, 0, 1, 0);

    // Overrun on fifth byte with no consumer
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 0);
    idle(1);
    check_val("ovr_sticky", overrun_sticky, 1);
    check_val("ovr_count", fifo_count, 4);
    check_val("ovr_head", rx_data, 8'h01);

    // Full FIFO with same-cycle pop: no overrun
    step(0, 0, 0, 0, 0, 0, 1);
    send_frame(8'h05, 1);
    idle(1);
    check_val("fullpop_count", fifo_count, 4);
    check_val("fullpop_head", rx_data, 8'h02);
    check_val("fullpop_sticky", overrun_sticky, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 0);

    // Rejected frames and saturation
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1'b1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(1);
    check_val("short_errcnt", err_cnt, 1);
    check_val("short_nopush", fifo_count, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    check_val("errpulse_cnt", err_cnt, 2);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    check_val("sat_errcnt", err_cnt, 255);

    // Reset mid-frame, then clean 0x3C frame
    for (int i = 0; i < 3; i++) step(0, 1, 1'b1, 0, 0, 0, 0);
    step(1, 1, 1'b1, 0, 0, 0, 0);
    send_frame(8'h3C, 0);
    idle(1);
    check_val("rst_data", rx_data, 8'h3C);
    check_val("rst_errcnt", err_cnt, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Clear with a same-cycle error keeps one count
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    idle(1);
    check_val("clr_err_cnt", err_cnt, 1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r, sh, b, d, e, rdy, clr;
      r   = ($urandom_range(0, 199) == 0);
      sh  = ($urandom_range(0, 1) == 1);
      b   = $urandom_range(0, 1);
      d   = (m_bcnt >= DB) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 39) == 0);
      e   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 49) == 0);
      step(r, sh, b, d, e, rdy, clr);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
